mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: forwards ALU results to writeback, or runs one load/store
// handshake per mem instruction. Optional access timeout under MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DATA_W         = 24,
    parameter int DEST_W         = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeback_enable,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [DEST_W-1:0] instruction_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_enable,
    output logic [DEST_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_error
);

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic              is_store;
        logic              wb_en;
        logic [DEST_W-1:0] dest;
    } req_t;

    state_t state;
    req_t   req;
    logic   mem_op;
    logic   tmo_hit;
    logic   done;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign mem_op = mem_read_enable | mem_write_enable;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit   = 1'b0;
    assign mem_error = 1'b0;
`endif

    // Ack wins over a timeout landing on the same cycle.
    assign done  = dmem_ack | tmo_hit;
    assign stall = !rst && ((state == IDLE && mem_op) || (state == ACCESS && !done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_enable  <= 1'b0;
            wb_dest    <= '0;
            wb_data    <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt    <= '0;
            mem_error  <= 1'b0;
`endif
        end else begin
            wb_valid  <= 1'b0;
            wb_enable <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            mem_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        req.is_store <= mem_write_enable;
                        req.wb_en    <= writeback_enable;
                        req.dest     <= instruction_dest;
                        dmem_addr    <= alu_result;
                        dmem_wdata   <= write_data;
                        dmem_req     <= 1'b1;
                        dmem_we      <= mem_write_enable;
                        state        <= ACCESS;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end else begin
                        wb_valid  <= writeback_enable;
                        wb_enable <= writeback_enable;
                        wb_dest   <= instruction_dest;
                        wb_data   <= alu_result;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_dest  <= req.dest;
                        if (dmem_ack) begin
                            // Stores retire their address; loads retire the returned data.
                            wb_enable <= req.wb_en & ~req.is_store;
                            wb_data   <= req.is_store ? dmem_addr : dmem_rdata;
                        end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                            mem_error <= 1'b1;
`endif
                        end
                    end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, load/store handshakes,
// reset abort, and timeout (or indefinite wait when MEM_ACCESS_TIMEOUT_EN is undefined).
module tb_mem_access_unit;

    localparam int DATA_W = 24;
    localparam int DEST_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              writeback_enable, mem_read_enable, mem_write_enable;
    logic [DEST_W-1:0] instruction_dest;
    logic [DATA_W-1:0] alu_result, write_data;
    logic              stall, dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid, wb_enable;
    logic [DEST_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              mem_error;

    int checks   = 0;
    int failures = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(DATA_W), .DEST_W(DEST_W), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .writeback_enable(writeback_enable), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .instruction_dest(instruction_dest),
        .alu_result(alu_result), .write_data(write_data),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_enable(wb_enable), .wb_dest(wb_dest),
        .wb_data(wb_data), .mem_error(mem_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        writeback_enable = 0; mem_read_enable = 0; mem_write_enable = 0;
        instruction_dest = '0; alu_result = '0; write_data = '0;
    endtask

    initial begin
        idle_in();
        dmem_ack = 0; dmem_rdata = '0; rst = 1;
        tick(); tick();
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mem_error", mem_error, 0);
        rst = 0;

        // ALU op with writeback
        writeback_enable = 1; instruction_dest = 3; alu_result = 24'h00ABCD;
        #1 chk("alu_stall_comb", stall, 0);
        tick();
        idle_in();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_enable", wb_enable, 1);
        chk("alu_wb_dest", wb_dest, 3);
        chk("alu_wb_data", wb_data, 24'h00ABCD);
        chk("alu_stall", stall, 0);

        // ALU op without writeback still registers dest/data
        instruction_dest = 7; alu_result = 24'h000111;
        tick();
        idle_in();
        chk("nowb_valid", wb_valid, 0);
        chk("nowb_enable", wb_enable, 0);
        chk("nowb_data", wb_data, 24'h000111);

        // Stray ack in IDLE is ignored
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        chk("stray_ack_req", dmem_req, 0);
        chk("stray_ack_valid", wb_valid, 0);

        // Load, acked on the 4th access cycle
        mem_read_enable = 1; writeback_enable = 1; instruction_dest = 5; alu_result = 24'h000010;
        stall_cnt = 0;
        #1 if (stall) stall_cnt++;
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            if (stall) stall_cnt++;
            chk("ld_req", dmem_req, 1);
            chk("ld_we", dmem_we, 0);
            chk("ld_addr", dmem_addr, 24'h000010);
            chk("ld_wb_valid_busy", wb_valid, 0);
            tick();
        end
        dmem_ack = 1; dmem_rdata = 24'h123456;
        #1 chk("ld_ack_stall", stall, 0);
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        chk("ld_stall_cycles", stall_cnt, 4);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_enable", wb_enable, 1);
        chk("ld_wb_dest", wb_dest, 5);
        chk("ld_wb_data", wb_data, 24'h123456);
        chk("ld_req_done", dmem_req, 0);

        // Store, acked immediately
        mem_write_enable = 1; writeback_enable = 1; instruction_dest = 2;
        alu_result = 24'h000020; write_data = 24'h0000FF;
        tick();
        idle_in();
        dmem_ack = 1;
        #1 chk("st_ack_stall", stall, 0);
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 24'h000020);
        chk("st_wdata", dmem_wdata, 24'h0000FF);
        tick();
        dmem_ack = 0;
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_enable", wb_enable, 0);
        chk("st_wb_data", wb_data, 24'h000020);
        chk("st_wb_dest", wb_dest, 2);
        chk("st_we_idle", dmem_we, 0);

        // Both enables act as a store; next op sees one IDLE cycle with req low
        mem_read_enable = 1; mem_write_enable = 1; writeback_enable = 1;
        instruction_dest = 1; alu_result = 24'h000030; write_data = 24'h0000AA;
        tick();
        idle_in();
        chk("both_we", dmem_we, 1);
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        chk("both_wb_enable", wb_enable, 0);
        chk("both_wb_data", wb_data, 24'h000030);
        mem_read_enable = 1; instruction_dest = 6; alu_result = 24'h000040;
        #1 chk("b2b_gap_req", dmem_req, 0);
        chk("b2b_gap_stall", stall, 1);
        tick();
        idle_in();
        chk("b2b_req", dmem_req, 1);
        chk("b2b_addr_hold", dmem_addr, 24'h000040);

        // Reset two cycles into the load, ack in the same cycle
        tick();
        rst = 1; dmem_ack = 1; dmem_rdata = 24'h000999;
        tick();
        rst = 0; dmem_ack = 0; dmem_rdata = '0;
        chk("rstld_req", dmem_req, 0);
        chk("rstld_wb_valid", wb_valid, 0);
        chk("rstld_wb_data", wb_data, 0);
        #1 chk("rstld_stall", stall, 0);
        tick();
        chk("rstld_wb_valid2", wb_valid, 0);

        // Load never acked
        mem_read_enable = 1; writeback_enable = 1; instruction_dest = 9; alu_result = 24'h000050;
        tick();
        idle_in();
`ifdef MEM_ACCESS_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req", dmem_req, 1);
            chk("tmo_err_early", mem_error, 0);
            tick();
        end
        chk("tmo_req_drop", dmem_req, 0);
        chk("tmo_err", mem_error, 1);
        chk("tmo_wb_valid", wb_valid, 1);
        chk("tmo_wb_enable", wb_enable, 0);
        chk("tmo_wb_dest", wb_dest, 9);
        tick();
        chk("tmo_err_pulse", mem_error, 0);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("wait_stall", stall, 1);
        chk("wait_req", dmem_req, 1);
        chk("wait_err", mem_error, 0);
        chk("wait_wb_valid", wb_valid, 0);
        dmem_ack = 1; dmem_rdata = 24'h0000C3;
        tick();
        dmem_ack = 0;
        chk("wait_done_valid", wb_valid, 1);
        chk("wait_done_data", wb_data, 24'h0000C3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
